// File: rtl/led_mode_ctrl_pkg.sv
// rtl/led_mode_ctrl_pkg.sv - shared mode encoding, board defaults and mode transition rule
package led_mode_ctrl_pkg;

    // Display modes; encoding 2'd3 is never produced.
    typedef enum logic [1:0] {
        MODE_BLINK    = 2'd0,
        MODE_CHASE_UP = 2'd1,
        MODE_CHASE_DN = 2'd2
    } mode_e;

    // Defaults for the 50 MHz board.
    localparam int DEF_DEB_CNT_W = 14;
    localparam int DEF_TICK_DIV  = 25_000_000;
    localparam int DEF_LED_W     = 4;

    // Next mode for a pair of key events. Key0 has priority; a coincident
    // key1 event is dropped.
    function automatic mode_e mode_next(input mode_e cur, input logic [1:0] evt);
        mode_e nxt;
        nxt = cur;
        if (evt[0]) begin
            nxt = (cur == MODE_CHASE_UP) ? MODE_BLINK : MODE_CHASE_UP;
        end else if (evt[1]) begin
            nxt = (cur == MODE_CHASE_DN) ? MODE_BLINK : MODE_CHASE_DN;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// rtl/led_mode_ctrl_if.sv - board-side signal bundle of the LED mode controller
// Signals:
//   key       raw push keys (1 = pressed), asynchronous
//   hold_i    freeze pattern stepping
//   key_evt_o one-cycle pulse per qualified press
//   mode_o    current display mode
//   led_o     registered LED drive (1 = on)
// Modports: master = board/stimulus side, slave = controller side.
interface led_mode_ctrl_if #(
    parameter int LED_W = 4
);
    logic [1:0]       key;
    logic             hold_i;
    logic [1:0]       key_evt_o;
    logic [1:0]       mode_o;
    logic [LED_W-1:0] led_o;

    modport master (
        output key,
        output hold_i,
        input  key_evt_o,
        input  mode_o,
        input  led_o
    );

    modport slave (
        input  key,
        input  hold_i,
        output key_evt_o,
        output mode_o,
        output led_o
    );
endinterface

// File: rtl/led_mode_ctrl_key_debounce.sv
// rtl/led_mode_ctrl_key_debounce.sv - single-key synchroniser, debouncer and press-edge pulse
// Ports:
//   clk_50m  system clock
//   rst      synchronous active-high reset
//   key      raw key, asynchronous, 1 = pressed
//   evt      one-cycle pulse per qualified press
module led_mode_ctrl_key_debounce #(
    parameter int DEB_CNT_W = 14
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic key,
    output logic evt
);

    logic                 key_ff1;
    logic                 ks;
    logic [DEB_CNT_W-1:0] cnt;
    logic                 stable;
    logic                 stable_d;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            key_ff1  <= 1'b0;
            ks       <= 1'b0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            evt      <= 1'b0;
        end else begin
            key_ff1 <= key;
            ks      <= key_ff1;
            // Saturate rather than wrap so a long hold never re-qualifies
            // (no auto-repeat); only a release clears the count.
            if (!ks) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            stable   <= ks & cnt[DEB_CNT_W-1];
            stable_d <= stable;
            evt      <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - key debouncing, LED display-mode FSM and pattern sequencer
// Ports:
//   clk_50m  system clock, 50 MHz
//   rst      synchronous active-high reset
//   ui       slave side of led_mode_ctrl_if (key, hold_i in; key_evt_o, mode_o, led_o out)
module led_mode_ctrl
    import led_mode_ctrl_pkg::*;
#(
    parameter int DEB_CNT_W = DEF_DEB_CNT_W,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int LED_W     = DEF_LED_W
) (
    input  logic           clk_50m,
    input  logic           rst,
    led_mode_ctrl_if.slave ui
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int PH_W  = $clog2(LED_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(LED_W - 1);

    logic [1:0]       key_evt;
    mode_e            mode_q;
    mode_e            mode_d;
    logic             mode_chg;
    logic [DIV_W-1:0] div_q;
    logic [PH_W-1:0]  phase_q;
    logic             blink_q;
    logic             tick;
    logic [LED_W-1:0] led_d;
    logic [LED_W-1:0] led_q;

    led_mode_ctrl_key_debounce #(.DEB_CNT_W(DEB_CNT_W)) u_deb_key0 (
        .clk_50m (clk_50m),
        .rst     (rst),
        .key     (ui.key[0]),
        .evt     (key_evt[0])
    );

    led_mode_ctrl_key_debounce #(.DEB_CNT_W(DEB_CNT_W)) u_deb_key1 (
        .clk_50m (clk_50m),
        .rst     (rst),
        .key     (ui.key[1]),
        .evt     (key_evt[1])
    );

    // Mode FSM: state register.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            mode_q <= MODE_BLINK;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode FSM: next state.
    always_comb begin
        mode_d   = mode_q;
        mode_chg = 1'b0;
        mode_d   = mode_next(mode_q, key_evt);
        mode_chg = (mode_d != mode_q);
    end

    // hold_i freezes the divider in place so stepping resumes mid-period.
    assign tick = !ui.hold_i && (div_q == DIV_LAST);

    // Divider and step state. A mode change restarts the pattern and takes
    // precedence over a tick landing in the same cycle.
    always_ff @(posedge clk_50m) begin
        if (rst || mode_chg) begin
            div_q   <= '0;
            phase_q <= '0;
            blink_q <= 1'b0;
        end else if (!ui.hold_i) begin
            if (tick) begin
                div_q   <= '0;
                blink_q <= ~blink_q;
                phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    // LED decode.
    always_comb begin
        led_d = '0;
        case (mode_q)
            MODE_BLINK:    led_d = {LED_W{blink_q}};
            MODE_CHASE_UP: led_d[phase_q] = 1'b1;
            MODE_CHASE_DN: led_d[PH_LAST - phase_q] = 1'b1;
            default:       led_d = '0;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign ui.key_evt_o = key_evt;
    assign ui.mode_o    = mode_q;
    assign ui.led_o     = led_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb/tb_led_mode_ctrl.sv - randomized self-checking bench for led_mode_ctrl
module tb_led_mode_ctrl;

    localparam int DW = 4;
    localparam int TD = 4;
    localparam int LW = 4;
    // ks must be high for this many consecutive cycles before stable rises
    localparam int NQ = (1 << (DW - 1)) + 1;

    logic clk_50m = 1'b0;
    logic rst;

    always #5 clk_50m = ~clk_50m;

    led_mode_ctrl_if #(.LED_W(LW)) ui ();

    led_mode_ctrl #(.DEB_CNT_W(DW), .TICK_DIV(TD), .LED_W(LW)) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .ui      (ui)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: synchroniser delay, run-length qualification,
    // mode/divider/pattern rules.
    bit       m_ff1 [2];
    bit       m_ks  [2];
    int       m_run [2];
    bit       m_st  [2];
    bit       m_std [2];
    bit       m_evt [2];
    int       m_mode;
    int       m_div;
    int       m_phase;
    bit       m_blink;
    bit [LW-1:0] m_led;

    function automatic bit [LW-1:0] led_of(input int mode, input int phase, input bit blink);
        bit [LW-1:0] v;
        v = '0;
        if (mode == 0)      v = blink ? '1 : '0;
        else if (mode == 1) v[phase] = 1'b1;
        else if (mode == 2) v[LW-1-phase] = 1'b1;
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit [1:0] k, input bit h);
        bit [1:0] ev;
        int nm;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                m_ff1[i] = 0; m_ks[i] = 0; m_run[i] = 0;
                m_st[i] = 0; m_std[i] = 0; m_evt[i] = 0;
            end
            m_mode = 0; m_div = 0; m_phase = 0; m_blink = 0; m_led = '0;
            return;
        end
        ev = {m_evt[1], m_evt[0]};
        for (int i = 0; i < 2; i++) begin
            m_evt[i] = m_st[i] & ~m_std[i];
            m_std[i] = m_st[i];
            m_run[i] = m_ks[i] ? ((m_run[i] < 1000) ? m_run[i] + 1 : m_run[i]) : 0;
            m_st[i]  = (m_run[i] >= NQ);
            m_ks[i]  = m_ff1[i];
            m_ff1[i] = k[i];
        end
        m_led = led_of(m_mode, m_phase, m_blink);
        nm = m_mode;
        if (ev[0])      nm = (m_mode == 1) ? 0 : 1;
        else if (ev[1]) nm = (m_mode == 2) ? 0 : 2;
        if (nm != m_mode) begin
            m_div = 0; m_phase = 0; m_blink = 0;
        end else if (!h) begin
            if (m_div == TD - 1) begin
                m_div   = 0;
                m_blink = ~m_blink;
                m_phase = (m_phase + 1) % LW;
            end else begin
                m_div++;
            end
        end
        m_mode = nm;
    endtask

    task automatic cycle();
        @(posedge clk_50m);
        model_edge(rst, ui.key, ui.hold_i);
        @(negedge clk_50m);
        chk("led_o", 32'(ui.led_o), 32'(m_led));
        chk("mode_o", 32'(ui.mode_o), 32'(m_mode));
        chk("key_evt_o", 32'(ui.key_evt_o), {30'd0, m_evt[1], m_evt[0]});
    endtask

    int  k_cnt [2];
    bit  k_val [2];
    bit  tie;
    int  h_cnt;
    bit  h_val;
    int  r_cnt;

    initial begin
        rst       = 1'b1;
        ui.key    = 2'b00;
        ui.hold_i = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (12) cycle();

        // key0 held long, then a short glitch
        ui.key = 2'b01;
        repeat (20) cycle();
        ui.key = 2'b00;
        repeat (6) cycle();
        ui.key = 2'b01;
        repeat (5) cycle();
        ui.key = 2'b00;
        repeat (15) cycle();

        // both keys with identical timing: key0 wins
        ui.key = 2'b11;
        repeat (20) cycle();
        ui.key = 2'b00;
        repeat (10) cycle();

        // key1 press into CHASE_DN, with a hold window
        ui.key = 2'b10;
        repeat (20) cycle();
        ui.key = 2'b00;
        repeat (7) cycle();
        ui.hold_i = 1'b1;
        repeat (20) cycle();
        ui.hold_i = 1'b0;
        repeat (10) cycle();

        // randomized phase
        k_cnt[0] = 0; k_cnt[1] = 0; k_val[0] = 0; k_val[1] = 0;
        h_cnt = 0; h_val = 0; r_cnt = 0; tie = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) tie = ($urandom % 3 == 0);
            for (int i = 0; i < 2; i++) begin
                if (k_cnt[i] == 0) begin
                    k_val[i] = ~k_val[i];
                    k_cnt[i] = k_val[i] ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 12));
                end else begin
                    k_cnt[i]--;
                end
            end
            ui.key = tie ? {k_val[0], k_val[0]} : {k_val[1], k_val[0]};
            if (h_cnt == 0) begin
                h_val = ~h_val;
                h_cnt = h_val ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 40));
            end else begin
                h_cnt--;
            end
            ui.hold_i = h_val;
            if (r_cnt > 0) begin
                rst = 1'b1;
                r_cnt--;
            end else begin
                rst = 1'b0;
                if ($urandom % 400 == 0) r_cnt = int'($urandom_range(1, 3));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
